uart_rx_ovs_fifo: RTL and testbench

Second-generation UART receiver with parametrised oversampling, 3-sample majority-vote bit recovery, framing checks and an RX FIFO.
- Frame format is run-time configurable: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
- Received frames plus per-frame status are buffered and drained through a valid/ready interface.
- Sits between the baud tick generator and the bus-side register block.

---
 rtl/uart_rx_ovs_fifo_if.sv | 18 +
 rtl/uart_rx_ovs_fifo.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_rx_ovs_fifo.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ovs_fifo_if.sv
// Consumer-side handshake of uart_rx_ovs_fifo: FIFO head data/status plus valid/ready.
// o_break is present only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_ovs_fifo_if;
  logic [7:0] o_data;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_valid;
  logic       i_ready;
`ifdef UART_RX_BREAK_DET_EN
  logic       o_break;

  modport master (output o_data, o_parity_err, o_frame_err, o_valid, o_break, input i_ready);
  modport slave  (input o_data, o_parity_err, o_frame_err, o_valid, o_break, output i_ready);
`else
  modport master (output o_data, o_parity_err, o_frame_err, o_valid, input i_ready);
  modport slave  (input o_data, o_parity_err, o_frame_err, o_valid, output i_ready);
`endif
endinterface

// File: rtl/uart_rx_ovs_fifo.sv
// Oversampling UART receiver (majority-vote bit recovery, framing checks) with RX FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_ovs_fifo #(
  parameter int OVS         = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_tick,
  input  logic [1:0]                      i_num_bit_data,
  input  logic                            i_parity_en,
  input  logic                            i_parity_type,
  input  logic                            i_stop_bits,
  input  logic                            i_rx_serial,
  uart_rx_ovs_fifo_if.master              rx_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
  output logic                            o_overrun,
  input  logic                            i_clr_overrun,
  output logic                            o_busy
);
  localparam int TW = $clog2(OVS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS / 2);
  localparam logic [TW-1:0] T_S2   = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
`ifdef UART_RX_BREAK_DET_EN
  localparam int EW = 11;
`else
  localparam int EW = 10;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2
`ifdef UART_RX_BREAK_DET_EN
    , BREAK_WAIT
`endif
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev, maj;
  logic [TW-1:0]          tick_cnt;
  logic                   samp0, samp1;
  logic [2:0]             bit_idx, nbits_m1;
  logic                   par_en_q, par_odd_q, stop2_q;
  logic [7:0]             data_q;
  logic                   perr_q, ferr_q, seen_one_q;
  logic                   push_q;
  logic [EW-1:0]          pend_q;

  logic [EW-1:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, rd_nx;
  logic [CW-1:0]          count_nx;
  logic [EW-1:0]          head_q, head_nx;
  logic                   valid_q, full, do_pop, do_push, ovr_set;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign maj  = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q[0] <= i_rx_serial;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      rx_prev <= rx_s;
    end
  end

  // Receiver FSM: tick_cnt is the tick index inside the current bit, restarted at start detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      tick_cnt   <= '0;
      samp0      <= 1'b0;
      samp1      <= 1'b0;
      bit_idx    <= '0;
      nbits_m1   <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      seen_one_q <= 1'b0;
      push_q     <= 1'b0;
      pend_q     <= '0;
    end else begin
      push_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state      <= START;
            o_busy     <= 1'b1;
            tick_cnt   <= '0;
            nbits_m1   <= {1'b1, i_num_bit_data};
            par_en_q   <= i_parity_en;
            par_odd_q  <= i_parity_type;
            stop2_q    <= i_stop_bits;
            bit_idx    <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            seen_one_q <= 1'b0;
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        // Line must stay high for a full bit period before a new start is accepted.
        BREAK_WAIT: begin
          if (rx_tick) begin
            if (!rx_s) begin
              tick_cnt <= '0;
            end else if (tick_cnt == T_LAST) begin
              state    <= IDLE;
              o_busy   <= 1'b0;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif
        default: begin
          if (rx_tick) begin
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
            if (tick_cnt == T_S0) samp0 <= rx_s;
            if (tick_cnt == T_S1) samp1 <= rx_s;
            if (tick_cnt == T_S2) begin
              case (state)
                START: begin
                  if (maj) begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                  end
                end
                DATA: begin
                  data_q[bit_idx] <= maj;
                  seen_one_q      <= seen_one_q | maj;
                end
                PARITY: begin
                  perr_q     <= maj ^ (^data_q) ^ par_odd_q;
                  seen_one_q <= seen_one_q | maj;
                end
                STOP1, STOP2: begin
                  ferr_q     <= ferr_q | ~maj;
                  seen_one_q <= seen_one_q | maj;
                  // Final stop sample: hand the frame to the FIFO and rearm at mid-stop.
                  if (state == STOP2 || !stop2_q) begin
                    push_q <= 1'b1;
                    state  <= IDLE;
                    o_busy <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                    pend_q <= {~(seen_one_q | maj), ferr_q | ~maj, perr_q, data_q};
                    if (!(seen_one_q | maj)) begin
                      state    <= BREAK_WAIT;
                      o_busy   <= 1'b1;
                      tick_cnt <= '0;
                    end
`else
                    pend_q <= {ferr_q | ~maj, perr_q, data_q};
`endif
                  end
                end
                default: ;
              endcase
            end
            if (tick_cnt == T_LAST) begin
              case (state)
                START:  state <= DATA;
                DATA: begin
                  if (bit_idx == nbits_m1) state <= par_en_q ? PARITY : STOP1;
                  else bit_idx <= bit_idx + 3'd1;
                end
                PARITY: state <= STOP1;
                STOP1:  state <= STOP2;
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign full    = (o_count == CW'(FIFO_DEPTH));
  assign do_pop  = valid_q && rx_if.i_ready;
  assign do_push = push_q && (!full || do_pop);
  assign ovr_set = push_q && full && !do_pop;

  // Next head: the pushed entry bypasses the RAM when nothing older remains.
  always_comb begin
    count_nx = o_count;
    if (do_push && !do_pop)      count_nx = o_count + CW'(1);
    else if (!do_push && do_pop) count_nx = o_count - CW'(1);
    rd_nx = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    if (count_nx == '0)                                   head_nx = '0;
    else if (o_count == '0 || (o_count == CW'(1) && do_pop)) head_nx = pend_q;
    else                                                  head_nx = mem[rd_nx];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_count   <= '0;
      valid_q   <= 1'b0;
      head_q    <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_nx;
      o_count <= count_nx;
      valid_q <= (count_nx != '0);
      head_q  <= head_nx;
      if (ovr_set)            o_overrun <= 1'b1;
      else if (i_clr_overrun) o_overrun <= 1'b0;
    end
  end

  assign rx_if.o_data       = head_q[7:0];
  assign rx_if.o_parity_err = head_q[8];
  assign rx_if.o_frame_err  = head_q[9];
  assign rx_if.o_valid      = valid_q;
`ifdef UART_RX_BREAK_DET_EN
  assign rx_if.o_break      = head_q[10];
`endif

endmodule

// File: tb/tb_uart_rx_ovs_fifo.sv
// Directed, table-driven bench for uart_rx_ovs_fifo (OVS=16, FIFO_DEPTH=4, tick every 4 clk).
// Break checks are compiled in when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx_ovs_fifo;
  localparam int OVS         = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TICK_DIV    = 4;
  localparam int BIT_CLKS    = OVS * TICK_DIV;
  localparam int CW          = $clog2(FIFO_DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_tick;
  logic [1:0]    i_num_bit_data;
  logic          i_parity_en, i_parity_type, i_stop_bits;
  logic          i_rx_serial, i_clr_overrun;
  logic [CW-1:0] o_count;
  logic          o_overrun, o_busy;
  int            n_checks = 0;
  int            n_fail   = 0;

  uart_rx_ovs_fifo_if rx_if();

  uart_rx_ovs_fifo #(.OVS(OVS), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_tick        (rx_tick),
    .i_num_bit_data (i_num_bit_data),
    .i_parity_en    (i_parity_en),
    .i_parity_type  (i_parity_type),
    .i_stop_bits    (i_stop_bits),
    .i_rx_serial    (i_rx_serial),
    .rx_if          (rx_if),
    .o_count        (o_count),
    .o_overrun      (o_overrun),
    .i_clr_overrun  (i_clr_overrun),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 rx_tick = 1'b1;
      @(posedge clk);
      #1 rx_tick = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [1:0] nb;
    logic       pe;
    logic       pt;
    logic       s2;
    logic [7:0] data;
    logic       flip_par;
    logic       st1_low;
    logic       st2_low;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    while (rx_if.o_valid !== 1'b1 && n < budget) begin
      wait_clks(1);
      n++;
    end
    checkOutput({name, "_valid_wait"}, 32'(rx_if.o_valid), 32'd1);
  endtask

  task automatic pop_one();
    rx_if.i_ready = 1'b1;
    wait_clks(1);
    rx_if.i_ready = 1'b0;
  endtask

  // Scrambling the config after the start bit exercises config latching.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pe,
                            input logic par_bit, input logic s2, input logic st1,
                            input logic st2, input bit scramble_cfg);
    logic [1:0] nb_save;
    logic       pe_save, pt_save, sb_save;
    nb_save = i_num_bit_data;
    pe_save = i_parity_en;
    pt_save = i_parity_type;
    sb_save = i_stop_bits;
    i_rx_serial = 1'b0;
    wait_clks(BIT_CLKS);
    if (scramble_cfg) begin
      i_num_bit_data = ~nb_save;
      i_parity_en    = ~pe_save;
      i_parity_type  = ~pt_save;
      i_stop_bits    = ~sb_save;
    end
    for (int i = 0; i < nbits; i++) begin
      i_rx_serial = data[i];
      wait_clks(BIT_CLKS);
    end
    if (pe) begin
      i_rx_serial = par_bit;
      wait_clks(BIT_CLKS);
    end
    i_rx_serial = st1;
    wait_clks(BIT_CLKS);
    if (s2) begin
      i_rx_serial = st2;
      wait_clks(BIT_CLKS);
    end
    i_rx_serial    = 1'b1;
    i_num_bit_data = nb_save;
    i_parity_en    = pe_save;
    i_parity_type  = pt_save;
    i_stop_bits    = sb_save;
  endtask

  task automatic applyStimulus(input vec_t v);
    int         nbits;
    logic [7:0] mask;
    logic       par;
    i_num_bit_data = v.nb;
    i_parity_en    = v.pe;
    i_parity_type  = v.pt;
    i_stop_bits    = v.s2;
    nbits = int'(v.nb) + 5;
    mask  = 8'hFF;
    mask  = mask >> (8 - nbits);
    par   = (^(v.data & mask)) ^ v.pt ^ v.flip_par;
    send_frame(v.data, nbits, v.pe, par, v.s2, ~v.st1_low, ~v.st2_low, 1'b1);
  endtask

  task automatic set_8n1();
    i_num_bit_data = 2'b11;
    i_parity_en    = 1'b0;
    i_parity_type  = 1'b0;
    i_stop_bits    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
    vecs[2] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{2'b00, 1'b1, 1'b1, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b1};
    vecs[6] = '{2'b01, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h3F, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1};
    vecs[8] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

    rst_n         = 1'b0;
    i_rx_serial   = 1'b1;
    i_clr_overrun = 1'b0;
    rx_if.i_ready = 1'b0;
    set_8n1();
    wait_clks(4);
    checkOutput("rst_data",  32'(rx_if.o_data), 32'h0);
    checkOutput("rst_perr",  32'(rx_if.o_parity_err), 32'h0);
    checkOutput("rst_ferr",  32'(rx_if.o_frame_err), 32'h0);
    checkOutput("rst_valid", 32'(rx_if.o_valid), 32'h0);
    checkOutput("rst_count", 32'(o_count), 32'h0);
    checkOutput("rst_ovr",   32'(o_overrun), 32'h0);
    checkOutput("rst_busy",  32'(o_busy), 32'h0);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);

    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k]);
      wait_valid(200, $sformatf("v%0d", k));
      checkOutput($sformatf("v%0d_count", k), 32'(o_count), 32'd1);
      checkOutput($sformatf("v%0d_data", k), 32'(rx_if.o_data), 32'(vecs[k].exp_data));
      checkOutput($sformatf("v%0d_perr", k), 32'(rx_if.o_parity_err), 32'(vecs[k].exp_perr));
      checkOutput($sformatf("v%0d_ferr", k), 32'(rx_if.o_frame_err), 32'(vecs[k].exp_ferr));
      pop_one();
      checkOutput($sformatf("v%0d_valid_after_pop", k), 32'(rx_if.o_valid), 32'd0);
      checkOutput($sformatf("v%0d_count_after_pop", k), 32'(o_count), 32'd0);
      wait_clks(2 * BIT_CLKS);
    end

`ifdef UART_RX_BREAK_DET_EN
    set_8n1();
    i_rx_serial = 1'b0;
    wait_clks(10 * BIT_CLKS);
    i_rx_serial = 1'b1;
    wait_valid(200, "brk");
    checkOutput("brk_flag", 32'(rx_if.o_break), 32'd1);
    checkOutput("brk_data", 32'(rx_if.o_data), 32'h0);
    checkOutput("brk_ferr", 32'(rx_if.o_frame_err), 32'd1);
    checkOutput("brk_busy_wait", 32'(o_busy), 32'd1);
    wait_clks(BIT_CLKS + 16);
    checkOutput("brk_busy_done", 32'(o_busy), 32'd0);
    pop_one();
    wait_clks(BIT_CLKS);
`endif

    // Short low glitch must not produce a frame.
    set_8n1();
    i_rx_serial = 1'b0;
    wait_clks(10);
    checkOutput("glitch_busy_high", 32'(o_busy), 32'd1);
    wait_clks(OVS / 4 * TICK_DIV - 10);
    i_rx_serial = 1'b1;
    wait_clks(BIT_CLKS);
    checkOutput("glitch_busy_low", 32'(o_busy), 32'd0);
    checkOutput("glitch_count", 32'(o_count), 32'd0);
    checkOutput("glitch_valid", 32'(rx_if.o_valid), 32'd0);

    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_valid(200, "b2b");
    checkOutput("b2b_count", 32'(o_count), 32'd2);
    checkOutput("b2b_head0", 32'(rx_if.o_data), 32'h55);
    pop_one();
    checkOutput("b2b_head1", 32'(rx_if.o_data), 32'hAA);
    checkOutput("b2b_count1", 32'(o_count), 32'd1);
    pop_one();
    checkOutput("b2b_count0", 32'(o_count), 32'd0);

    // 2-stop frame seen under 1-stop config, immediately followed by another frame.
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_valid(200, "xstop");
    checkOutput("xstop_count", 32'(o_count), 32'd2);
    checkOutput("xstop_head0", 32'(rx_if.o_data), 32'h81);
    checkOutput("xstop_ferr0", 32'(rx_if.o_frame_err), 32'd0);
    pop_one();
    checkOutput("xstop_head1", 32'(rx_if.o_data), 32'h7E);
    checkOutput("xstop_ferr1", 32'(rx_if.o_frame_err), 32'd0);
    pop_one();

    for (int f = 1; f <= 4; f++) send_frame(8'(f), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("ovr_full_count", 32'(o_count), 32'd4);
    checkOutput("ovr_not_yet", 32'(o_overrun), 32'd0);
    send_frame(8'h05, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("ovr_count", 32'(o_count), 32'd4);
    checkOutput("ovr_flag", 32'(o_overrun), 32'd1);
    for (int f = 1; f <= 4; f++) begin
      checkOutput($sformatf("ovr_head%0d", f), 32'(rx_if.o_data), 32'(f));
      pop_one();
    end
    checkOutput("ovr_drained", 32'(o_count), 32'd0);
    checkOutput("ovr_sticky", 32'(o_overrun), 32'd1);
    i_clr_overrun = 1'b1;
    wait_clks(1);
    i_clr_overrun = 1'b0;
    checkOutput("ovr_cleared", 32'(o_overrun), 32'd0);

    // Reset in the middle of a frame with a full FIFO and overrun set.
    for (int f = 0; f < 5; f++) send_frame(8'h11 + 8'(f), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    i_rx_serial = 1'b0;
    wait_clks(3 * BIT_CLKS);
    checkOutput("mid_busy", 32'(o_busy), 32'd1);
    checkOutput("mid_ovr", 32'(o_overrun), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_busy",  32'(o_busy), 32'd0);
    checkOutput("mrst_count", 32'(o_count), 32'd0);
    checkOutput("mrst_valid", 32'(rx_if.o_valid), 32'd0);
    checkOutput("mrst_ovr",   32'(o_overrun), 32'd0);
    checkOutput("mrst_data",  32'(rx_if.o_data), 32'h0);
    checkOutput("mrst_ferr",  32'(rx_if.o_frame_err), 32'd0);
    i_rx_serial = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    checkOutput("post_rst_busy", 32'(o_busy), 32'd0);
    checkOutput("post_rst_count", 32'(o_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
